// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR front-end sample serializer.
package fir_pkg;

    // Default PCM sample width used across the FIR front end
    localparam int DATA_WIDTH = 24;

    // One parallel signed PCM sample
    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    // Serializer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/sample_serializer_if.sv
// Bundle of the serializer's sample-side and serial-side handshake signals.
// The producer/consumer side drives through master; the serializer side is slave.
interface sample_serializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  en;
    logic [DATA_WIDTH-1:0] sample;
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  ready;
    logic                  dout;
    logic                  dout_valid;

    modport master (
        output en, sample, sample_valid, ready,
        input  sample_ready, dout, dout_valid
    );

    modport slave (
        input  en, sample, sample_valid, ready,
        output sample_ready, dout, dout_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and an occupancy count.
// Pushes when full and pops when empty are ignored; read data is the
// current head word, available combinationally.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers, count and storage; pointers wrap naturally at DEPTH
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so it is not reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/sample_serializer.sv
// Parallel-to-serial converter feeding the FIR serial input.
// Samples are buffered in a small FIFO, then shifted out LSB first while
// o_dout_valid is high; each word is followed by a guaranteed idle gap.
// i_en low freezes everything; i_rst abandons any word in flight.
module sample_serializer #(
    parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    input  logic                         i_sample_valid,
    output logic                         o_sample_ready,
    input  logic                         i_ready,
    output logic                         o_dout,
    output logic                         o_dout_valid
);
    import fir_pkg::*;

    localparam int CW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);

    state_e                  state_q,   state_d;
    logic [DATA_WIDTH-1:0]   shift_q,   shift_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [DATA_WIDTH-1:0]   fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FAW:0]            fifo_count;

    // Accept only while enabled, out of reset and with room in the buffer
    assign o_sample_ready = i_en && !i_rst && (fifo_count < (FAW+1)'(FIFO_DEPTH));
    assign fifo_push      = i_sample_valid && o_sample_ready && !fifo_full;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (i_sample),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serial outputs follow the registered state directly, so they hold
    // automatically whenever the FSM is frozen by i_en
    assign o_dout_valid = (state_q == SHIFT);
    assign o_dout       = (state_q == SHIFT) && shift_q[0];

    // Serializer FSM: load from FIFO, shift on downstream ready, then gap
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        fifo_pop  = 1'b0;
        if (i_en) begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_dout;
                        bit_cnt_d = '0;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (i_ready) begin
                        shift_d = shift_q >> 1;
                        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                            bit_cnt_d = '0;
                            gap_cnt_d = '0;
                            state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM registers; reset drops any partially sent word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end
endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer: accepted samples are queued as
// expected words; a negedge monitor deserializes the bit stream and compares.
module tb_sample_serializer;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst;

    sample_serializer_if #(.DATA_WIDTH(DW)) sif ();

    sample_serializer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .GAP_CYCLES (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (sif.en),
        .i_sample       (sif.sample),
        .i_sample_valid (sif.sample_valid),
        .o_sample_ready (sif.sample_ready),
        .i_ready        (sif.ready),
        .o_dout         (sif.dout),
        .o_dout_valid   (sif.dout_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q [$];
    int            mon_nbits   = 0;
    int            words_out   = 0;
    int            last_run    = 0;
    int            run_len     = 0;
    int            gap_len     = 0;
    int            min_gap     = 1000;
    bit            prev_seen   = 1'b0;
    bit            rand_mode   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", nm, act, req);
        end
    endtask

    // Monitor: deserialize on negedge; a bit is consumed at the next posedge
    // when valid, ready and enable are all high and reset is low.
    initial begin
        logic [DW-1:0] word;
        logic [DW-1:0] e;
        word = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_nbits = 0;
                run_len   = 0;
                gap_len   = 0;
                prev_seen = 1'b0;
            end else if (sif.en) begin
                if (sif.dout_valid) begin
                    if (run_len == 0 && prev_seen && gap_len < min_gap) min_gap = gap_len;
                    run_len++;
                    if (sif.ready) begin
                        word[mon_nbits] = sif.dout;
                        mon_nbits++;
                        if (mon_nbits == DW) begin
                            mon_nbits = 0;
                            words_out++;
                            prev_seen = 1'b1;
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected_word: actual %h, required none", word);
                            end else begin
                                e = exp_q.pop_front();
                                check("word_out", 32'(word), 32'(e));
                            end
                        end
                    end
                end else begin
                    if (run_len > 0) begin
                        last_run = run_len;
                        run_len  = 0;
                        gap_len  = 0;
                    end
                    gap_len++;
                end
            end
        end
    end

    // Offer one sample until accepted; the expected word is queued on accept
    task automatic push(input logic [DW-1:0] s);
        bit ok;
        ok = 1'b0;
        sif.sample       = s;
        sif.sample_valid = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (sif.sample_ready) begin
                ok = 1'b1;
                exp_q.push_back(s);
            end
            @(posedge clk);
            #1;
            if (rand_mode) sif.ready = ($urandom_range(0, 3) != 0);
            if (ok) break;
        end
        sif.sample_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: actual not accepted, required accepted %h", s);
        end
    endtask

    // Return once the word in flight has exactly n bits consumed
    task automatic wait_bits(input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (sif.dout_valid && mon_nbits == n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_bits_timeout: actual %0d bits, required %0d", mon_nbits, n);
        end
    endtask

    // Wait until every queued word has been emitted and the line is idle
    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (!sif.dout_valid && exp_q.size() == 0 && mon_nbits == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: actual %0d words pending, required 0", exp_q.size());
        end
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] vals [6];
        logic [DW-1:0] held;
        int            acc;
        int            v;

        rst              = 1'b1;
        sif.en           = 1'b1;
        sif.sample       = '0;
        sif.sample_valid = 1'b0;
        sif.ready        = 1'b1;

        // Reset state
        @(negedge clk);
        check("ready_in_reset", 32'(sif.sample_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(sif.dout_valid), 32'd0);
        check("rst_dout", 32'(sif.dout), 32'd0);
        check("rst_ready", 32'(sif.sample_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single word 800001 with continuous ready, plus load latency
        push(24'h800001);
        @(negedge clk);
        check("latency_pre", 32'(sif.dout_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("latency_rise", 32'(sif.dout_valid), 32'd1);
        check("first_bit", 32'(sif.dout), 32'd1);
        wait_idle(200);
        check("run_800001", 32'(last_run), 32'd24);

        // A5A5A5 with ready held low for 5 cycles while bit 3 is presented
        push(24'hA5A5A5);
        wait_bits(3);
        sif.ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_dout", 32'(sif.dout), 32'd0);
            check("stall_valid", 32'(sif.dout_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        sif.ready = 1'b1;
        wait_idle(200);
        check("run_a5a5a5", 32'(last_run), 32'd29);

        // Six back-to-back samples with downstream stalled
        vals[0] = 24'h000001;
        vals[1] = 24'h7FFFFF;
        vals[2] = 24'h800000;
        vals[3] = 24'hFFFFFF;
        vals[4] = 24'h0F0F0F;
        vals[5] = 24'hC3C3C3;
        sif.ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            sif.sample       = vals[i];
            sif.sample_valid = 1'b1;
            @(negedge clk);
            if (sif.sample_ready) begin
                acc++;
                exp_q.push_back(vals[i]);
            end
            @(posedge clk);
            #1;
        end
        sif.sample_valid = 1'b0;
        check("accepted_count", 32'(acc), 32'd5);
        @(negedge clk);
        check("full_ready_low", 32'(sif.sample_ready), 32'd0);
        @(posedge clk);
        #1;
        sif.ready = 1'b1;
        push(vals[5]);
        wait_idle(1000);
        check("words_after_burst", 32'(words_out), 32'd8);

        // Reset mid-word abandons 123456, then 00FFFF goes out intact
        push(24'h123456);
        wait_bits(10);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(sif.dout_valid), 32'd0);
        check("post_rst_count", 32'(dut.fifo_count), 32'd0);
        check("post_rst_ready", 32'(sif.sample_ready), 32'd1);
        @(posedge clk);
        #1;
        push(24'h00FFFF);
        wait_idle(200);
        check("run_00ffff", 32'(last_run), 32'd24);

        // Enable dropped for 3 cycles mid-word
        push(24'h5A5A5A);
        wait_bits(8);
        held = '0;
        held[0] = sif.dout;
        sif.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("freeze_dout", 32'(sif.dout), 32'(held[0]));
            check("freeze_valid", 32'(sif.dout_valid), 32'd1);
            check("freeze_ready", 32'(sif.sample_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        sif.en = 1'b1;
        wait_idle(200);

        // 200 Hz sine at 48 kHz, 220 samples, random downstream ready
        rand_mode = 1'b1;
        for (int i = 0; i < 220; i++) begin
            v = $rtoi($sin(2.0 * 3.14159265358979 * 200.0 * real'(i) / 48000.0) * 8000000.0);
            held = v[DW-1:0];
            push(held);
        end
        rand_mode = 1'b0;
        sif.ready = 1'b1;
        wait_idle(20000);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("total_words", 32'(words_out), 32'd230);
        check("min_gap", 32'(min_gap), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
